// File: rtl/lookupflow_learn_if.sv
// Lookup request/response bundle between the rx parser,
// the learning MAC table and the forwarding crossbar.
interface lookupflow_learn_if #(
  parameter int NPORT = 4,
  parameter int CW    = 4
);
  logic             req;
  logic [95:0]      tuple;
  logic [NPORT-1:0] src_port;
  logic             cmd_mode;
  logic [NPORT-1:0] cmd_fwd_port;
  logic             flush;
  logic             ack;
  logic [NPORT-1:0] fwd_port;
  logic             hit;
  logic             busy;
  logic [CW-1:0]    entry_count;

  modport master (
    output req, tuple, src_port, cmd_mode,
    output cmd_fwd_port, flush,
    input  ack, fwd_port, hit, busy, entry_count
  );

  modport slave (
    input  req, tuple, src_port, cmd_mode,
    input  cmd_fwd_port, flush,
    output ack, fwd_port, hit, busy, entry_count
  );
endinterface

// File: rtl/lookupflow_learn.sv
// Learning MAC table: src learning, station move, aging, flush.
// Three-cycle lookup returning a forward port mask per request.
module lookupflow_learn #(
  parameter int NPORT    = 4,
  parameter int DEPTH    = 8,
  parameter int AGE_W    = 4,
  parameter int AGE_TICK = 1000000
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  lookupflow_learn_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(AGE_TICK);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             hit_q, hit_d;
  logic [NPORT-1:0] fwd_q, fwd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    rptr_q, rptr_d;

  logic [47:0]      dst_q, dst_d;
  logic [47:0]      src_q, src_d;
  logic [NPORT-1:0] sport_q, sport_d;
  logic             mode_q, mode_d;
  logic [NPORT-1:0] cfwd_q, cfwd_d;

  logic             dhit_q, dhit_d;
  logic [NPORT-1:0] dport_q, dport_d;
  logic             shit_q, shit_d;
  logic [IW-1:0]    sidx_q, sidx_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [47:0]      mac_q  [DEPTH];
  logic [47:0]      mac_d  [DEPTH];
  logic [NPORT-1:0] port_q [DEPTH];
  logic [NPORT-1:0] port_d [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [AGE_W-1:0] age_d  [DEPTH];

  logic             tick;
  logic             dm_any, sm_any, free_any;
  logic [NPORT-1:0] dm_port;
  logic [IW-1:0]    sm_idx, free_idx, widx;
  logic             learn_en;

  assign tick = (presc_q == PW'(AGE_TICK - 1));

  always_comb begin
    dm_any   = 1'b0;
    dm_port  = '0;
    sm_any   = 1'b0;
    sm_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    cnt_d    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mac_q[i] == dst_q) begin
        dm_any  = 1'b1;
        dm_port = port_q[i];
      end
      if (valid_q[i] && mac_q[i] == src_q) begin
        sm_any = 1'b1;
        sm_idx = IW'(i);
      end
      cnt_d = cnt_d + CW'(valid_q[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    hit_d    = hit_q;
    fwd_d    = fwd_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    rptr_d   = rptr_q;
    dst_d    = dst_q;
    src_d    = src_q;
    sport_d  = sport_q;
    mode_d   = mode_q;
    cfwd_d   = cfwd_q;
    dhit_d   = dhit_q;
    dport_d  = dport_q;
    shit_d   = shit_q;
    sidx_d   = sidx_q;
    valid_d  = valid_q;
    mac_d    = mac_q;
    port_d   = port_q;
    age_d    = age_q;
    learn_en = 1'b0;
    widx     = '0;

    if (tick) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          age_d[i] = age_q[i] - AGE_W'(1);
          if (age_q[i] == AGE_W'(1)) valid_d[i] = 1'b0;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          dst_d   = bus.tuple[95:48];
          src_d   = bus.tuple[47:0];
          sport_d = bus.src_port;
          mode_d  = bus.cmd_mode;
          cfwd_d  = bus.cmd_fwd_port;
          busy_d  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        dhit_d  = dm_any;
        dport_d = dm_port;
        shit_d  = sm_any;
        sidx_d  = sm_idx;
        state_d = S_RESP;
      end
      S_RESP: begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        hit_d   = 1'b0;
        if (!mode_q) begin
          fwd_d = cfwd_q;
        end else if (dst_q[40]) begin
          fwd_d = ~sport_q;
        end else if (dhit_q) begin
          hit_d = 1'b1;
          fwd_d = (dport_q == sport_q) ? '0 : dport_q;
        end else begin
          fwd_d = ~sport_q;
        end
        learn_en = mode_q && !src_q[40] &&
                   $onehot(sport_q) && !bus.flush;
      end
      default: state_d = S_IDLE;
    endcase

    // refresh/replace overrides the aging decrement above
    if (learn_en) begin
      if (shit_q) begin
        widx = sidx_q;
      end else if (free_any) begin
        widx = free_idx;
      end else begin
        widx   = rptr_q;
        rptr_d = (rptr_q == IW'(DEPTH - 1)) ?
                 '0 : rptr_q + IW'(1);
      end
      valid_d[widx] = 1'b1;
      mac_d[widx]   = src_q;
      port_d[widx]  = sport_q;
      age_d[widx]   = AGE_MAX;
    end

    if (bus.flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
      fwd_q   <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      rptr_q  <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      sport_q <= '0;
      mode_q  <= 1'b0;
      cfwd_q  <= '0;
      dhit_q  <= 1'b0;
      dport_q <= '0;
      shit_q  <= 1'b0;
      sidx_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      fwd_q   <= fwd_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      rptr_q  <= rptr_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      sport_q <= sport_d;
      mode_q  <= mode_d;
      cfwd_q  <= cfwd_d;
      dhit_q  <= dhit_d;
      dport_q <= dport_d;
      shit_q  <= shit_d;
      sidx_q  <= sidx_d;
      valid_q <= valid_d;
      mac_q   <= mac_d;
      port_q  <= port_d;
      age_q   <= age_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.fwd_port    = fwd_q;
  assign bus.hit         = hit_q;
  assign bus.busy        = busy_q;
  assign bus.entry_count = cnt_q;
endmodule

// File: doc/lookupflow_learn.md
Name: lookupflow_learn

Overview:
- Parametrised learning successor to the static per-port flow lookup: a DEPTH-entry MAC table with source-address learning, station-move update, aging and flush.
- Sits between the port receive parser (96-bit tuple = dst MAC [95:48], src MAC [47:0]) and the forwarding crossbar.
- Returns a one-hot/multi-hot NPORT-wide forward mask per request.
- Static mode (cmd_mode=0) passes cmd_fwd_port through with identical latency.

Parameters:
NPORT, 4, number of switch ports / width of port masks
DEPTH, 8, table entries (>=2)
AGE_W, 4, per-entry age counter width; AGE_MAX = 2^AGE_W-1
AGE_TICK, 1000000, sys_clk cycles per aging tick (>=2)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
req  in  1  lookup request, sampled only when busy=0
tuple  in  96  {dst MAC, src MAC}, sampled with req
src_port  in  NPORT  one-hot ingress port, sampled with req
cmd_mode  in  1  1=learning lookup, 0=static; sampled with req
cmd_fwd_port  in  NPORT  static forward mask; sampled with req
flush  in  1  invalidate all entries
ack  out  1  one-cycle result strobe
fwd_port  out  NPORT  forward mask, valid when ack=1, held until next ack
hit  out  1  dst found in table; valid with ack
busy  out  1  request in flight
entry_count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (async assert, sync release): all entries invalid, ages 0, replace pointer 0, tick prescaler 0; ack=0, fwd_port=0, hit=0, busy=0, entry_count=0. Reset mid-request abandons the request; no ack is issued.
- FSM IDLE -> LOOKUP -> RESP -> IDLE.
  - Edge E0: req=1 in IDLE: capture inputs, go LOOKUP, busy=1.
  - E1: parallel compare of captured dst and src against all valid entries, results registered, go RESP.
  - E2: ack=1 for exactly one cycle, fwd_port/hit updated, learn write performed, go IDLE, busy=0.
  - Next request may be accepted at E3 (back-to-back, one request per 3 cycles).
  - req while busy is ignored and not queued.
- Forwarding, cmd_mode=1:
  - dst group bit (tuple[88]) set (broadcast/multicast): fwd = ~src_port, hit=0.
  - dst hit on entry k with port p: fwd = p, except p==src_port gives fwd=0 (filter); hit=1.
  - miss: flood fwd = ~src_port, hit=0.
- Forwarding, cmd_mode=0: fwd=cmd_fwd_port, hit=0, no learning, no table change.
- Learning at E2 (cmd_mode=1 only):
  - Skipped if the src group bit (tuple[40]) is set, or src_port is not exactly one-hot.
  - src hit: overwrite port with src_port (station move), age=AGE_MAX.
  - src miss: write into the lowest-index invalid entry. If the table is full, write the entry at the replace pointer and advance the pointer, wrapping DEPTH-1 -> 0. Written entry is valid with age=AGE_MAX.
- Lookup uses table state before this request's learn write, so dst==src on a new MAC floods.
- Aging:
  - Prescaler counts 0..AGE_TICK-1; wrap produces a one-cycle tick.
  - On tick, every valid entry decrements age; an entry decremented from 1 to 0 becomes invalid.
  - The replace pointer is unaffected by aging and flush.
- Simultaneous events:
  - flush beats learn and tick: all entries invalid that cycle. An in-flight request still acks, using results already registered, but its learn write is dropped if flush is high at E2.
  - Learn refresh beats tick on the same entry: age=AGE_MAX.
- entry_count is registered and reflects table state one cycle after each change.

Test Plan:
- Reset then cmd_mode=1, src_port=0001, tuple={0023df85302a, 406c8f39ba77} -> ack 2 edges after accept, fwd=1110, hit=0, entry_count=1.
- Then src_port=0010, tuple={406c8f39ba77, 0023df85302a} -> fwd=0001, hit=1; reverse direction from 0001 -> fwd=0010, hit=1. Same MAC pair from port 0001 with dst on 0001 -> fwd=0000.
- Broadcast dst ffffffffffff from 0100 -> fwd=1011. Multicast src 010000000001 -> no learn, entry_count unchanged. cmd_mode=0, cmd_fwd_port=1000 -> fwd=1000, hit=0, no table change.
- DEPTH=4: learn 5 distinct src MACs -> count saturates at 4; 5th overwrites entry 0, so a lookup of the 1st MAC misses and floods. Move a known MAC to a new port -> subsequent hit returns the new port.
- AGE_W=2, AGE_TICK=16: learn one MAC, idle 3 ticks (48 cycles) -> entry invalid, count=0. Refresh just before the 3rd tick keeps it valid. Flush with req held on E1 -> ack still issued, count=0 after.
- Hold req high continuously -> exactly one ack per 3 cycles. Assert sys_rst_n=0 during LOOKUP -> outputs 0 immediately, no ack after release.
